// File: rtl/physical_line_memory_if.sv
// Line-memory request/response bundle between the processor physicalmem port and the backing store.
interface physical_line_memory_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned LINE_W = 128
) ();
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_response;

   modport master (
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata, mem_response
   );

   modport slave (
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata, mem_response
   );
endinterface

// File: rtl/physical_line_memory.sv
// Line-granular physical memory with a fixed, programmable request-to-response latency.
// Storage powers up zeroed and is never cleared by rst.
module physical_line_memory #(
   parameter int unsigned DELAY  = 10,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned LINE_W = 128,
   parameter int unsigned DEPTH  = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   physical_line_memory_if.slave  bus
);

   localparam int unsigned IDX_W = ADDR_W - 4;
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RESPOND = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              wr_q, wr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic [LINE_W-1:0] rdata_q, rdata_d;
   logic              resp_q, resp_d;

   logic [LINE_W-1:0] line_mem_q [DEPTH] = '{default: '0};

   logic              req_c;
   logic              mem_we_c;
   logic [IDX_W-1:0]  acc_idx_c;
   logic              acc_wr_c;
   logic [LINE_W-1:0] acc_wdata_c;
   logic              addr_unused_c;

   // Byte offset within a line has no effect on line-granular accesses.
   assign addr_unused_c = ^bus.mem_addr[3:0];

   // Next-state, request latching and the single response edge.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      wr_d        = wr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      resp_d      = 1'b0;
      mem_we_c    = 1'b0;
      acc_idx_c   = idx_q;
      acc_wr_c    = wr_q;
      acc_wdata_c = wdata_q;
      req_c       = bus.mem_read | bus.mem_write;

      unique case (state_q)
         IDLE: begin
            // With DELAY==1 the response edge is the accept edge, so use the live bus fields.
            acc_idx_c   = bus.mem_addr[ADDR_W-1:4];
            acc_wr_c    = bus.mem_write;
            acc_wdata_c = bus.mem_wdata;
            if (req_c) begin
               idx_d   = acc_idx_c;
               wr_d    = acc_wr_c;
               wdata_d = acc_wdata_c;
               cnt_d   = CNT_LOAD;
               if (DELAY == 1) begin
                  state_d = RESPOND;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            if (!req_c) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = RESPOND;
               end
            end
         end
         RESPOND: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Entering RESPOND is the one edge that commits the access.
      if (state_d == RESPOND) begin
         resp_d = 1'b1;
         if (acc_wr_c) begin
            mem_we_c = ~rst;
         end else begin
            rdata_d = line_mem_q[acc_idx_c];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         resp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         resp_q  <= resp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         line_mem_q[acc_idx_c] <= acc_wdata_c;
      end
   end

   assign bus.mem_rdata    = rdata_q;
   assign bus.mem_response = resp_q;

endmodule

// File: doc/physical_line_memory.md
Name: physical_line_memory

Overview:
- Line-granular physical memory stage directly downstream of the processor top level's physicalmem port.
- Serves 128-bit line reads and writes over a 16-bit byte address with a programmable fixed latency, using the mem_read/mem_write/mem_response handshake.
- Used as the backing store in top-level simulation.
- Written synthesizably so it can also back FPGA bring-up.

Parameters:
- DELAY, 10, cycles from request acceptance to mem_response (legal range 1..255).
- ADDR_W, 16, byte address width.
- LINE_W, 128, line width in bits (16 bytes).
- DEPTH, 4096, number of lines stored (2^(ADDR_W-4)).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  read request; held until mem_response.
- mem_write  input  1  write request; held until mem_response.
- mem_addr  input  ADDR_W  byte address; line index = mem_addr[15:4], bits [3:0] ignored.
- mem_wdata  input  LINE_W  write line data.
- mem_rdata  output  LINE_W  read line data.
- mem_response  output  1  one-cycle completion pulse.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- Reset:
  - mem_response=0, mem_rdata=0, FSM=IDLE, latency counter=0.
  - Line storage is not cleared by rst. It is zero-initialised at time 0 only.
- FSM states: IDLE, BUSY, RESPOND.
- IDLE:
  - If mem_read|mem_write is sampled high at a rising edge, accept the request.
  - On accept, latch line index, op and wdata; load counter with DELAY-1; go to BUSY.
  - If DELAY==1, go directly to RESPOND.
- Operation priority: if mem_read and mem_write are both high at accept, the operation is a write.
- BUSY:
  - Decrement the counter each cycle. When counter==1, next state is RESPOND.
  - If mem_read and mem_write are both low at any BUSY edge, abort: return to IDLE, no response, storage untouched.
- RESPOND:
  - Entered on the edge that raises mem_response.
  - Read: mem_rdata is loaded with storage[latched index] on that same edge.
  - Write: storage[latched index] is updated on that same edge.
  - mem_response is high for exactly one cycle. The next state is IDLE unconditionally; requests are not sampled in RESPOND.
- Latency: first request-high cycle T in IDLE gives mem_response high in cycle T+DELAY.
- Back-to-back requests: the earliest next acceptance is the cycle after RESPOND. This gives a minimum of one dead cycle between transactions.
- Latched request fields: address, op and wdata are latched at accept. Changes during BUSY are ignored, except that full deassertion aborts.
- mem_rdata hold: holds the last read line until the next read response. Writes do not change mem_rdata.
- Read-after-write: a read of a line written by the previous transaction returns the new data.
- Reset mid-operation: rst in BUSY or RESPOND forces IDLE and mem_response=0 next cycle. A pending write is dropped, unless rst coincides with the RESPOND edge itself, where rst wins and no write occurs.
- Address wrap: none. Every 16-bit address maps to exactly one line.

Test Plan:
- Basic write/read:
  - Stimulus: DELAY=10. Write addr 0x1230, wdata 0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, asserted at cycle 5.
  - Required: mem_response high in cycle 15 only.
  - Then read 0x123F. Required: response exactly 10 cycles after its first request cycle, mem_rdata equals the written line.
- Latency sweep:
  - Stimulus: DELAY=1, read asserted at cycle 3.
  - Required: mem_response in cycle 4, single pulse. Holding read through cycle 4 does not start a new transaction until cycle 5.
- Abort:
  - Stimulus: write to 0x0040 at cycle 0, deassert both strobes at cycle 4 (DELAY=10).
  - Required: no mem_response through cycle 20. A subsequent read of 0x0040 returns 0.
- Read/write conflict:
  - Stimulus: mem_read=mem_write=1 to 0x8000, wdata all-ones.
  - Required: treated as a write. mem_rdata unchanged. A later read returns 128'hFFFF…FFFF.
- Reset mid-transaction:
  - Stimulus: write 0xAAAA…AAAA to 0x0100, rst pulsed one cycle in BUSY.
  - Required: mem_response=0 and mem_rdata=0 the following cycle, no response for that request. A read of 0x0100 returns 0.
- Address latch:
  - Stimulus: start a read of 0x0010, change mem_addr to 0x0020 during BUSY.
  - Required: returned data is line 0x001 contents, not line 0x002.
